// File: rtl/lzw_pkg.sv
// Shared LZW definitions for the 12-bit compressor and decompressor.
// Holds code/byte widths, dictionary geometry and the decoder state encoding.
package lzw_pkg;

  localparam int unsigned CODE_W          = 12;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned FIRST_FREE_CODE = 256;
  localparam int unsigned DICT_DEPTH      = 1 << CODE_W;
  // Longest string: one literal plus one byte per dictionary entry.
  localparam int unsigned STACK_DEPTH     = DICT_DEPTH - 255;
  localparam int unsigned STACK_PTR_W     = $clog2(STACK_DEPTH + 1);

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_EMIT,
    ST_ERROR
  } dec_state_t;

endpackage

// File: rtl/lzw_dict_ram.sv
// LZW dictionary storage: prefix code and suffix byte per entry.
// Ports:
//   clk_i        clock
//   wr_en        write enable (one new entry per decoded code)
//   wr_addr      entry being created
//   wr_prefix    prefix code of the new entry
//   wr_suffix    suffix byte of the new entry
//   rd_addr      entry being walked
//   rd_prefix_c  prefix of rd_addr (combinational)
//   rd_suffix_c  suffix of rd_addr (combinational)
module lzw_dict_ram
  import lzw_pkg::*;
(
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [CODE_W-1:0] wr_addr,
  input  logic [CODE_W-1:0] wr_prefix,
  input  logic [BYTE_W-1:0] wr_suffix,
  input  logic [CODE_W-1:0] rd_addr,
  output logic [CODE_W-1:0] rd_prefix_c,
  output logic [BYTE_W-1:0] rd_suffix_c
);

  code_t prefix_mem [DICT_DEPTH];
  byte_t suffix_mem [DICT_DEPTH];

  // Contents are never cleared; entries are always written before being read.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      prefix_mem[wr_addr] <= wr_prefix;
      suffix_mem[wr_addr] <= wr_suffix;
    end
  end

  // Combinational read lets the walk push one byte per cycle.
  assign rd_prefix_c = prefix_mem[rd_addr];
  assign rd_suffix_c = suffix_mem[rd_addr];

endmodule

// File: rtl/lzw_decoder.sv
// Streaming 12-bit LZW decompressor.
// Ports:
//   clk_i, reset_i     clock, asynchronous active-high reset
//   code_i/_valid_i/_last_i/_ready_o   input code stream (valid/ready)
//   byte_o/_valid_o/_last_o, byte_ready_i   decoded byte stream (valid/ready)
//   err_o              sticky illegal-code flag
//   dict_size_o        next free dictionary code (256..4096)
module lzw_decoder
  import lzw_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              code_valid_i,
  input  logic              code_last_i,
  output logic              code_ready_o,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              byte_last_o,
  input  logic              byte_ready_i,
  output logic              err_o,
  output logic [CODE_W:0]   dict_size_o
);

  dec_state_t             state;
  logic [CODE_W:0]        next_code;
  logic                   first_code;
  code_t                  code_q;
  code_t                  prev_code;
  code_t                  cur;
  byte_t                  first_char;
  logic                   kwk;
  logic                   last_q;
  logic [STACK_PTR_W-1:0] sp;
  byte_t                  stack_mem [STACK_DEPTH];

  code_t rd_prefix_c;
  byte_t rd_suffix_c;
  logic  push_c;
  byte_t push_data_c;
  logic  cur_is_lit_c;
  logic  walk_done_c;
  logic  dict_we_c;
  logic  code_legal_c;
  logic  pop_c;

  lzw_dict_ram u_dict (
    .clk_i       (clk_i),
    .wr_en       (dict_we_c),
    .wr_addr     (next_code[CODE_W-1:0]),
    .wr_prefix   (prev_code),
    .wr_suffix   (cur[BYTE_W-1:0]),
    .rd_addr     (cur),
    .rd_prefix_c (rd_prefix_c),
    .rd_suffix_c (rd_suffix_c)
  );

  // Walk/pop control and code legality.
  always_comb begin
    push_c       = (state == ST_WALK);
    cur_is_lit_c = (cur < CODE_W'(FIRST_FREE_CODE));
    walk_done_c  = push_c && !kwk && cur_is_lit_c;
    if (kwk) begin
      push_data_c = first_char;
    end else if (cur_is_lit_c) begin
      push_data_c = cur[BYTE_W-1:0];
    end else begin
      push_data_c = rd_suffix_c;
    end
    // New entry = previous string + first byte of this string (cur at walk end).
    dict_we_c    = walk_done_c && !first_code &&
                   (next_code < (CODE_W+1)'(DICT_DEPTH));
    code_legal_c = ({1'b0, code_i} < next_code) ||
                   (({1'b0, code_i} == next_code) && !first_code);
    pop_c        = (state == ST_EMIT) && byte_valid_o && byte_ready_i;
  end

  // LIFO of decoded bytes; the walk yields the string back to front.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      stack_mem[sp] <= push_data_c;
    end
  end

  // Decoder FSM with registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= ST_IDLE;
      code_ready_o <= 1'b1;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      byte_last_o  <= 1'b0;
      err_o        <= 1'b0;
      next_code    <= (CODE_W+1)'(FIRST_FREE_CODE);
      first_code   <= 1'b1;
      code_q       <= '0;
      prev_code    <= '0;
      cur          <= '0;
      first_char   <= '0;
      kwk          <= 1'b0;
      last_q       <= 1'b0;
      sp           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (code_valid_i) begin
            code_ready_o <= 1'b0;
            code_q       <= code_i;
            cur          <= code_i;
            last_q       <= code_last_i;
            if (code_legal_c) begin
              state <= ST_WALK;
              kwk   <= ({1'b0, code_i} == next_code);
            end else begin
              state <= ST_ERROR;
              err_o <= 1'b1;
            end
          end
        end
        ST_WALK: begin
          sp <= sp + STACK_PTR_W'(1);
          if (kwk) begin
            // KwKwK: trailing byte is the previous string's first byte.
            kwk <= 1'b0;
            cur <= prev_code;
          end else if (!cur_is_lit_c) begin
            cur <= rd_prefix_c;
          end else begin
            first_char   <= cur[BYTE_W-1:0];
            prev_code    <= code_q;
            first_code   <= 1'b0;
            if (dict_we_c) begin
              next_code <= next_code + (CODE_W+1)'(1);
            end
            state        <= ST_EMIT;
            byte_valid_o <= 1'b1;
            byte_o       <= cur[BYTE_W-1:0];
            byte_last_o  <= last_q && (sp == STACK_PTR_W'(0));
          end
        end
        ST_EMIT: begin
          if (pop_c) begin
            sp <= sp - STACK_PTR_W'(1);
            if (sp > STACK_PTR_W'(1)) begin
              byte_o      <= stack_mem[sp - STACK_PTR_W'(2)];
              byte_last_o <= last_q && (sp == STACK_PTR_W'(2));
            end else begin
              byte_valid_o <= 1'b0;
              byte_last_o  <= 1'b0;
              code_ready_o <= 1'b1;
              state        <= ST_IDLE;
              // End of stream: the next code starts an independent stream.
              if (last_q) begin
                next_code  <= (CODE_W+1)'(FIRST_FREE_CODE);
                first_code <= 1'b1;
              end
            end
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dict_size_o = next_code;

endmodule

// File: tb/tb_lzw_decoder.sv
// Scoreboard bench for lzw_decoder with a queue-based LZW reference model.
module tb_lzw_decoder;
  import lzw_pkg::*;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [CODE_W-1:0] code_i;
  logic              code_valid_i;
  logic              code_last_i;
  logic              code_ready_o;
  logic [BYTE_W-1:0] byte_o;
  logic              byte_valid_o;
  logic              byte_last_o;
  logic              byte_ready_i;
  logic              err_o;
  logic [CODE_W:0]   dict_size_o;

  lzw_decoder dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .code_last_i  (code_last_i),
    .code_ready_o (code_ready_o),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_last_o  (byte_last_o),
    .byte_ready_i (byte_ready_i),
    .err_o        (err_o),
    .dict_size_o  (dict_size_o)
  );

  always #5 clk_i = ~clk_i;

  typedef logic [7:0] b8_t;
  typedef b8_t bq_t [$];
  typedef struct {
    logic [7:0] b;
    logic       last;
    int         ds;
  } exp_t;

  exp_t exp_q [$];
  bq_t  rx;
  bq_t  dict [4096];
  int   m_next;
  bit   m_first;
  bq_t  m_prev;
  bit   exp_err;

  int total = 0;
  int bad   = 0;
  bit bp_mode = 1'b0;
  bit ready_fixed = 1'b1;

  bit         prev_stall = 1'b0;
  logic [7:0] prev_b;
  logic       prev_last;

  task automatic check(string name, bit ok, longint act, longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_text(string name, string req);
    string s = "";
    foreach (rx[i]) s = {s, $sformatf("%c", rx[i])};
    total++;
    if (s != req) begin
      bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, s, req);
    end
  endtask

  // Reference model: plain LZW decode over byte queues.
  task automatic model_reset();
    m_next  = 256;
    m_first = 1'b1;
    m_prev.delete();
    exp_err = 1'b0;
  endtask

  function automatic bit model_legal(int c);
    return (c < m_next) || (c == m_next && !m_first && m_next < 4096);
  endfunction

  task automatic model_code(int c, bit last);
    bq_t cur;
    bq_t e;
    if (c < m_next) begin
      cur = dict[c];
    end else begin
      cur = m_prev;
      cur.push_back(m_prev[0]);
    end
    if (!m_first && m_next < 4096) begin
      e = m_prev;
      e.push_back(cur[0]);
      dict[m_next] = e;
      m_next++;
    end
    foreach (cur[i]) exp_q.push_back('{b: cur[i], last: last && (i == cur.size() - 1), ds: m_next});
    m_prev  = cur;
    m_first = 1'b0;
    if (last) begin
      m_next  = 256;
      m_first = 1'b1;
    end
  endtask

  function automatic int rand_code();
    if (m_first) return int'($urandom_range(0, 255));
    return int'($urandom_range(0, (m_next < 4096) ? m_next : 4095));
  endfunction

  // Sink readiness: random when backpressure is on.
  initial begin
    byte_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      byte_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: pops the scoreboard on every byte handshake.
  always @(negedge clk_i) begin
    exp_t e;
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_stable", byte_valid_o && byte_o == prev_b && byte_last_o == prev_last,
              {byte_valid_o, byte_o, byte_last_o}, {1'b1, prev_b, prev_last});
      if (byte_valid_o)
        check("code_ready_in_emit", code_ready_o == 1'b0, code_ready_o, 0);
      if (byte_valid_o && byte_ready_i) begin
        rx.push_back(byte_o);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 1'b0, byte_o, -1);
        end else begin
          e = exp_q.pop_front();
          check("byte", byte_o == e.b, byte_o, e.b);
          check("byte_last", byte_last_o == e.last, byte_last_o, e.last);
          check("dict_size_emit", int'(dict_size_o) == e.ds, dict_size_o, e.ds);
        end
      end
      prev_stall = byte_valid_o && !byte_ready_i;
      prev_b     = byte_o;
      prev_last  = byte_last_o;
    end
  end

  task automatic send(int c, bit last);
    int n = 0;
    if (model_legal(c)) model_code(c, last);
    else exp_err = 1'b1;
    @(posedge clk_i);
    #1;
    code_i       = 12'(c);
    code_last_i  = last;
    code_valid_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (code_ready_o) break;
      n++;
      if (n > 5000) begin
        check("accept_timeout", 1'b0, n, 5000);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    code_valid_i = 1'b0;
    code_last_i  = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(exp_q.size() == 0 && code_ready_o && !byte_valid_o) && n < 20000);
    check({name, "_drain"}, exp_q.size() == 0 && code_ready_o && !byte_valid_o, exp_q.size(), 0);
    check({name, "_dict_size"}, int'(dict_size_o) == m_next, dict_size_o, m_next);
  endtask

  // Asserts reset immediately, checks outputs, then releases after two edges.
  task automatic do_reset(string name);
    #1;
    reset_i      = 1'b1;
    code_valid_i = 1'b0;
    code_last_i  = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check(name, {code_ready_o, byte_valid_o, byte_o, byte_last_o, err_o, dict_size_o} ==
                {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 13'd256},
          {code_ready_o, byte_valid_o, byte_o, byte_last_o, err_o, dict_size_o},
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 13'd256});
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  int banana [10] = '{98, 97, 110, 257, 97, 95, 256, 110, 100, 259};

  initial begin
    int n;
    int len;
    reset_i      = 1'b1;
    code_i       = '0;
    code_valid_i = 1'b0;
    code_last_i  = 1'b0;
    for (int i = 0; i < 256; i++) dict[i].push_back(8'(i));
    model_reset();
    @(negedge clk_i);
    do_reset("reset_state");

    // Reference text stream with an always-ready sink.
    rx.delete();
    foreach (banana[i]) send(banana[i], i == 9);
    wait_idle("banana");
    check_text("banana_text", "banana_bandana");

    // KwKwK on the second code.
    rx.delete();
    send(97, 1'b0);
    send(256, 1'b0);
    send(97, 1'b1);
    wait_idle("kwk");
    check_text("kwk_text", "aaaa");

    // Same text under random backpressure.
    bp_mode = 1'b1;
    rx.delete();
    foreach (banana[i]) send(banana[i], i == 9);
    wait_idle("banana_bp");
    check_text("banana_bp_text", "banana_bandana");

    // Random legal streams under backpressure.
    for (int s = 0; s < 4; s++) begin
      len = int'($urandom_range(5, 40));
      for (int k = 0; k < len; k++) send(rand_code(), k == len - 1);
      wait_idle("random_stream");
    end
    bp_mode = 1'b0;

    // Fill the dictionary, run past saturation, then use the last entry.
    for (int k = 0; k < 3843; k++) send(65, 1'b0);
    wait_idle("dict_full");
    check("dict_saturated", dict_size_o == 13'd4096, dict_size_o, 4096);
    send(4095, 1'b1);
    wait_idle("dict_full_tail");

    // Reset while a multi-byte string is stalled in EMIT.
    @(negedge clk_i);
    do_reset("reset_pre_emit");
    send(98, 1'b0);
    send(97, 1'b0);
    send(110, 1'b0);
    wait_idle("pre_emit");
    ready_fixed = 1'b0;
    send(257, 1'b0);
    n = 0;
    while (!byte_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("emit_reached", byte_valid_o, byte_valid_o, 1);
    do_reset("reset_mid_emit");
    ready_fixed = 1'b1;
    rx.delete();
    send(98, 1'b0);
    send(97, 1'b1);
    wait_idle("after_reset");
    check_text("after_reset_text", "ba");

    // Illegal first code.
    @(negedge clk_i);
    do_reset("reset_pre_err1");
    send(300, 1'b0);
    repeat (4) @(negedge clk_i);
    check("err_first_code", err_o == exp_err && !code_ready_o && !byte_valid_o,
          {err_o, code_ready_o, byte_valid_o}, {exp_err, 2'b00});
    repeat (10) @(negedge clk_i);
    check("err_sticky", err_o == exp_err && !code_ready_o && !byte_valid_o,
          {err_o, code_ready_o, byte_valid_o}, {exp_err, 2'b00});

    // Code beyond next_code mid-stream.
    @(negedge clk_i);
    do_reset("reset_pre_err2");
    send(98, 1'b0);
    send(97, 1'b0);
    send(110, 1'b0);
    wait_idle("pre_err2");
    send(270, 1'b0);
    repeat (4) @(negedge clk_i);
    check("err_too_big", err_o == exp_err && !code_ready_o && !byte_valid_o,
          {err_o, code_ready_o, byte_valid_o}, {exp_err, 2'b00});
    @(negedge clk_i);
    do_reset("reset_after_err");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
